// File: rtl/demultiplexer_3_8.sv
// Registered 1-to-2**SEL_W demultiplexer with one cycle of latency.
// Optional macro DEMUX_HOLD_EN: keep the last routed pattern while en is low.

module demultiplexer_3_8_lane #(
    parameter int SEL_W = 3,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             in,
    output logic             q
);
    logic hit;

    assign hit = (sel == SEL_W'(IDX));

    // sel is only looked at under en, so an undriven sel while idle never reaches q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (en) begin
            q <= in & hit;
        end else begin
`ifdef DEMUX_HOLD_EN
            q <= q;
`else
            q <= 1'b0;
`endif
        end
    end
endmodule

module demultiplexer_3_8 #(
    parameter int SEL_W = 3,
    parameter int OUT_N = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic             in,
    output logic [OUT_N-1:0] out,
    output logic             out_valid
);
    // One flop per destination line; exactly one lane can match a given sel.
    for (genvar i = 0; i < OUT_N; i++) begin : g_lane
        demultiplexer_3_8_lane #(
            .SEL_W (SEL_W),
            .IDX   (i)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .sel   (sel),
            .in    (in),
            .q     (out[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= en;
        end
    end
endmodule

// File: tb/tb_demultiplexer_3_8.sv
// Bench for demultiplexer_3_8: directed vectors plus a shift-based reference model.

module tb_demultiplexer_3_8;
    localparam int SEL_W = 3;
    localparam int OUT_N = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [SEL_W-1:0] sel = '0;
    logic             in = 1'b0;
    logic [OUT_N-1:0] out;
    logic             out_valid;

    int checks = 0;
    int passes = 0;
    bit run = 1'b0;

    logic [OUT_N-1:0] m_out;
    logic             m_vld;

    demultiplexer_3_8 #(.SEL_W(SEL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .sel       (sel),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Reference: a sample routes in to bit position sel, i.e. in shifted left by sel.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_out <= '0;
            m_vld <= 1'b0;
        end else if (en) begin
            m_out <= OUT_N'(in) << sel;
            m_vld <= 1'b1;
        end else begin
`ifdef DEMUX_HOLD_EN
            m_out <= m_out;
`else
            m_out <= '0;
`endif
            m_vld <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [OUT_N-1:0] act, input logic [OUT_N-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (run) begin
            chk("model_out", out, m_out);
            chk("model_valid", OUT_N'(out_valid), OUT_N'(m_vld));
            chk("onehot", OUT_N'($countones(out) <= 1), OUT_N'(1));
        end
    end

    // Apply inputs, then look just past the capturing edge.
    task automatic cyc(input logic e, input logic [SEL_W-1:0] s, input logic d);
        en = e; sel = s; in = d;
        @(posedge clk); #1;
    endtask

    logic [OUT_N-1:0] sweep_exp [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [OUT_N-1:0] idle_exp;

    initial begin
`ifdef DEMUX_HOLD_EN
        idle_exp = 8'h40;
`else
        idle_exp = 8'h00;
`endif
        run = 1'b1;
        // Reset held with a live request on the inputs
        en = 1'b1; sel = 3'b101; in = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_out", out, 8'h00);
            chk("rst_valid", OUT_N'(out_valid), 8'h00);
        end
        rst_n = 1'b1;
        cyc(1'b1, 3'b101, 1'b1);
        chk("first_out", out, 8'h20);
        chk("first_valid", OUT_N'(out_valid), 8'h01);

        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, SEL_W'(k), 1'b1);
            chk("sweep_out", out, sweep_exp[k]);
            chk("sweep_valid", OUT_N'(out_valid), 8'h01);
        end

        // Mid-cycle async reset while out = 80
        #2 rst_n = 1'b0;
        #1;
        chk("async_out", out, 8'h00);
        chk("async_valid", OUT_N'(out_valid), 8'h00);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, SEL_W'(k), 1'b1);
            chk("resume_out", out, sweep_exp[k]);
        end

        cyc(1'b1, 3'b011, 1'b0);
        chk("zero_out", out, 8'h00);
        chk("zero_valid", OUT_N'(out_valid), 8'h01);

        cyc(1'b1, 3'b110, 1'b1);
        chk("cap_out", out, 8'h40);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 3'bxxx, 1'b1);
            chk("idle_out", out, idle_exp);
            chk("idle_valid", OUT_N'(out_valid), 8'h00);
        end

        for (int k = 0; k < 1000; k++)
            cyc(1'($urandom_range(0, 1)), SEL_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

        @(negedge clk);
        run = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/demultiplexer_3_8.md
Name: demultiplexer_3_8

Overview:
Registered 1-to-8 demultiplexer. Routes a single-bit input to one of 2**SEL_W output lines chosen by a binary select. All other lines are driven low. Used as a decode/steer stage wherever one serial bit or strobe must be fanned out to one of N destinations. Output is registered with one cycle of latency.

Parameters:
SEL_W, 3, select width in bits; output count OUT_N = 2**SEL_W (default 8); legal range 1..6.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst_n  input  1  asynchronous active-low reset.
en  input  1  sample enable; when low, no new routing is captured.
sel  input  SEL_W  binary index of the destination line.
in  input  1  data bit to route.
out  output  OUT_N  demultiplexed lines; out[sel] carries in, all others 0.
out_valid  output  1  high for the cycle in which out reflects a sample taken with en=1.

Behaviour:
- Reset: rst_n low forces out = 0 and out_valid = 0 immediately, independent of clk. Both hold while rst_n is low. The first capture occurs on the first rising clk edge after rst_n deasserts.
- Capture: on each rising clk edge with rst_n high and en=1:
  - out[i] <= in when i == sel, else 0, for every i in 0..OUT_N-1.
  - out_valid <= 1.
- Latency: exactly 1 clock from en/sel/in sampled to out/out_valid.
- Idle: on a rising edge with en=0, out <= 0 and out_valid <= 0. This is the baseline; the optional feature below changes it.
- One-hot invariant: at most one bit of out is 1 at any time.
  - in=0 with en=1 gives out = 0 and out_valid = 1. A valid "zero routed" result is distinguishable from idle only by out_valid.
- Back-to-back: sel and in may change every cycle with en held high. Each edge produces an independent result with no bubbles.
- Full select range: every value 0..OUT_N-1 is legal; there is no wrap-around or out-of-range case.
- Reset mid-operation: asserting rst_n clears out and out_valid asynchronously in the same cycle. Any in-flight result is discarded.
- No combinational path from inputs to outputs; all outputs come straight from flops.
- X/Z on sel while en=0 must not propagate to out.

Optional Feature:
Macro DEMUX_HOLD_EN.
- Defined: on an edge with en=0, out keeps its previous value and out_valid <= 0. The last routed pattern stays visible until the next capture or reset.
- Not defined: on an edge with en=0, out clears to 0, as in baseline Behaviour.
- Reset behaviour is identical in both builds: out = 0, out_valid = 0.

Test Plan:
- Reset: hold rst_n=0 with en=1, in=1, sel=3'b101 and clock running. Required: out=8'h00 and out_valid=0 throughout. After release, the first edge gives out=8'h20 and out_valid=1.
- Select sweep: en=1, in=1, sel stepping 0..7 on consecutive cycles. Required: out one cycle later = 8'h01, 02, 04, 08, 10, 20, 40, 80; out_valid stays 1.
- Zero data: en=1, in=0, sel=3'b011. Required: out=8'h00 and out_valid=1 on the next cycle.
- Enable low: capture sel=3'b110, in=1, then drop en for 3 cycles. Required without DEMUX_HOLD_EN: out=8'h00 and out_valid=0 from the next edge. Required with DEMUX_HOLD_EN: out stays 8'h40 and out_valid=0.
- Async reset mid-stream: with out=8'h80, pulse rst_n low between clock edges. Required: out=8'h00 and out_valid=0 before the next rising edge. The sweep then resumes correctly after release.
- Random: 1000 cycles of random en, sel, in. Required: out always matches the one-cycle-delayed reference model and is always zero or one-hot.
